// File: rtl/pipeline_stage.sv
// pipeline_stage
//   Single pipeline register stage with valid/ready handshaking on both sides.
//   It carries NUM_WORDS datapath words, a control bundle and a destination
//   index, and counts the cycles in which a held beat is stalled downstream.
//
//   Build option PIPELINE_STAGE_SKID_EN adds a one-entry skid buffer. This
//   registers in_ready, so there is no combinational path from out_ready to
//   in_ready, and gives a capacity of two beats. Without the macro the stage
//   holds one beat and in_ready = !out_valid | out_ready.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   flush        discard every held beat, including one accepted on this edge
//   in_valid     upstream beat valid
//   in_ready     stage can accept a beat
//   in_words     NUM_WORDS packed words, word 0 in the LSBs
//   in_ctrl      control bundle
//   in_dest      destination register index
//   out_valid    held beat valid
//   out_ready    downstream can take the beat
//   out_words    held words
//   out_ctrl     held control bundle
//   out_dest     held destination index
//   stall_count  saturating count of edges with out_valid=1 and out_ready=0
module pipeline_stage #(
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned NUM_WORDS  = 4,
  parameter int unsigned CTRL_WIDTH = 40,
  parameter int unsigned DEST_WIDTH = 3,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            flush,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_WORDS*WORD_WIDTH-1:0] in_words,
  input  logic [CTRL_WIDTH-1:0]           in_ctrl,
  input  logic [DEST_WIDTH-1:0]           in_dest,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_WORDS*WORD_WIDTH-1:0] out_words,
  output logic [CTRL_WIDTH-1:0]           out_ctrl,
  output logic [DEST_WIDTH-1:0]           out_dest,
  output logic [CNT_WIDTH-1:0]            stall_count
);

  localparam int unsigned DW = NUM_WORDS * WORD_WIDTH;
  localparam int unsigned PW = DW + CTRL_WIDTH + DEST_WIDTH;

  // Payload is handled as one packed vector: {dest, ctrl, words}.
  logic [PW-1:0]        in_pl;
  logic [PW-1:0]        main_pl_q, main_pl_d;
  logic                 main_valid_q, main_valid_d;
  logic [CNT_WIDTH-1:0] stall_q, stall_d;
  logic                 accept;

  assign in_pl  = {in_dest, in_ctrl, in_words};
  assign accept = in_valid & in_ready;

  assign out_valid   = main_valid_q;
  assign out_words   = main_pl_q[DW-1:0];
  assign out_ctrl    = main_pl_q[DW +: CTRL_WIDTH];
  assign out_dest    = main_pl_q[DW+CTRL_WIDTH +: DEST_WIDTH];
  assign stall_count = stall_q;

  always_comb begin
    stall_d = stall_q;
    if (main_valid_q && !out_ready && (stall_q != '1)) begin
      stall_d = stall_q + CNT_WIDTH'(1);
    end
  end

`ifdef PIPELINE_STAGE_SKID_EN

  logic          skid_valid_q, skid_valid_d;
  logic [PW-1:0] skid_pl_q, skid_pl_d;
  logic          rdy_q, rdy_d;

  assign in_ready = rdy_q;

  // The skid entry only fills while main is full and stalled, and in_ready is
  // low while it is full, so a skid->main move never coincides with an accept.
  always_comb begin
    main_valid_d = main_valid_q;
    main_pl_d    = main_pl_q;
    skid_valid_d = skid_valid_q;
    skid_pl_d    = skid_pl_q;
    if (!main_valid_q || out_ready) begin
      if (skid_valid_q) begin
        main_pl_d    = skid_pl_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_pl_d    = in_pl;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_pl_d    = in_pl;
      skid_valid_d = 1'b1;
    end
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end
    rdy_d = !skid_valid_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      main_pl_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_pl_q    <= '0;
      rdy_q        <= 1'b1;
      stall_q      <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_pl_q    <= main_pl_d;
      skid_valid_q <= skid_valid_d;
      skid_pl_q    <= skid_pl_d;
      rdy_q        <= rdy_d;
      stall_q      <= stall_d;
    end
  end

`else

  assign in_ready = !main_valid_q | out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_pl_d    = main_pl_q;
    if (accept) begin
      main_pl_d    = in_pl;
      main_valid_d = 1'b1;
    end else if (out_ready) begin
      main_valid_d = 1'b0;
    end
    if (flush) begin
      main_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      main_pl_q    <= '0;
      stall_q      <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_pl_q    <= main_pl_d;
      stall_q      <= stall_d;
    end
  end

`endif

endmodule

// File: tb/tb_pipeline_stage.sv
// Randomized and scenario-driven bench for pipeline_stage. The reference is a
// queue of accepted beats: its size gives the occupancy, its head gives the
// expected output. A second instance with a 4-bit counter exercises saturation.
module tb_pipeline_stage;

  localparam int unsigned WW = 16;
  localparam int unsigned NW = 4;
  localparam int unsigned CW = 40;
  localparam int unsigned DW = 3;
  localparam int unsigned PW = NW*WW + CW + DW;
`ifdef PIPELINE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, flush, in_valid, out_ready;
  logic [NW*WW-1:0] in_words;
  logic [CW-1:0]    in_ctrl;
  logic [DW-1:0]    in_dest;

  logic             in_ready, out_valid;
  logic [NW*WW-1:0] out_words;
  logic [CW-1:0]    out_ctrl;
  logic [DW-1:0]    out_dest;
  logic [15:0]      stall_count;

  logic             s_in_ready, s_out_valid;
  logic [NW*WW-1:0] s_out_words;
  logic [CW-1:0]    s_out_ctrl;
  logic [DW-1:0]    s_out_dest;
  logic [3:0]       s_stall_count;

  always #5 clk = ~clk;

  pipeline_stage #(.WORD_WIDTH(WW), .NUM_WORDS(NW), .CTRL_WIDTH(CW),
                   .DEST_WIDTH(DW), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .in_words(in_words), .in_ctrl(in_ctrl),
    .in_dest(in_dest), .out_valid(out_valid), .out_ready(out_ready),
    .out_words(out_words), .out_ctrl(out_ctrl), .out_dest(out_dest),
    .stall_count(stall_count));

  pipeline_stage #(.WORD_WIDTH(WW), .NUM_WORDS(NW), .CTRL_WIDTH(CW),
                   .DEST_WIDTH(DW), .CNT_WIDTH(4)) dut_sat (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_ready(s_in_ready), .in_words(in_words), .in_ctrl(in_ctrl),
    .in_dest(in_dest), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_words(s_out_words), .out_ctrl(s_out_ctrl), .out_dest(s_out_dest),
    .stall_count(s_stall_count));

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  task automatic chk(input bit ok, input string name,
                     input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference state
  logic [PW-1:0] held[$];
  int unsigned   stall_m = 0;

  function automatic int unsigned sat(input int unsigned v, input int unsigned max);
    return (v > max) ? max : v;
  endfunction

  // Monitor / scoreboard: inputs and outputs are settled at the falling edge,
  // and they are exactly what the next rising edge will act on.
  always @(negedge clk) begin
    logic [PW-1:0] outp, inp;
    bit exp_rdy;
    outp = {out_dest, out_ctrl, out_words};
    inp  = {in_dest, in_ctrl, in_words};
    if (reset) begin
      chk(out_valid == 1'b0, "reset_out_valid", 128'(out_valid), 128'(0));
      chk(outp == '0, "reset_payload", 128'(outp), 128'(0));
      chk(stall_count == '0, "reset_stall", 128'(stall_count), 128'(0));
      held.delete();
      stall_m = 0;
    end else begin
      exp_rdy = SKID ? (held.size() < 2) : (held.size() == 0 || out_ready);
      chk(in_ready == exp_rdy, "in_ready", 128'(in_ready), 128'(exp_rdy));
      chk(out_valid == (held.size() != 0), "out_valid", 128'(out_valid),
          128'(held.size() != 0));
      if (held.size() != 0)
        chk(outp == held[0], "out_payload", 128'(outp), 128'(held[0]));
      chk(stall_count == 16'(sat(stall_m, 16'hFFFF)), "stall_count",
          128'(stall_count), 128'(sat(stall_m, 16'hFFFF)));
      chk(s_stall_count == 4'(sat(stall_m, 15)), "stall_count_sat4",
          128'(s_stall_count), 128'(sat(stall_m, 15)));
      if (held.size() != 0 && !out_ready) stall_m++;
      if (flush) begin
        held.delete();
      end else begin
        if (held.size() != 0 && out_ready) void'(held.pop_front());
        if (in_valid && exp_rdy) held.push_back(inp);
      end
    end
  end

  task automatic cyc(input bit v, input logic [NW*WW-1:0] w, input bit rdy, input bit fl);
    in_valid  = v;
    in_words  = w;
    in_ctrl   = {$urandom, $urandom};
    in_dest   = DW'($urandom);
    out_ready = rdy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NW*WW-1:0] rnd_words();
    return {$urandom, $urandom};
  endfunction

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_words = '0; in_ctrl = '0; in_dest = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1 chk(in_ready == 1'b1, "ready_after_reset", 128'(in_ready), 128'(1));

    // Back-to-back streaming with the sink always ready
    for (int unsigned i = 1; i <= 8; i++) cyc(1'b1, (NW*WW)'(i), 1'b1, 1'b0);
    repeat (3) cyc(1'b0, rnd_words(), 1'b1, 1'b0);

    // Backpressure on 0xBEEF while upstream keeps offering
    cyc(1'b1, (NW*WW)'(16'hBEEF), 1'b0, 1'b0);
    repeat (5) cyc(1'b1, rnd_words(), 1'b0, 1'b0);
    repeat (4) cyc(1'b0, rnd_words(), 1'b1, 1'b0);

    // Flush with a held beat and a concurrent offer
    cyc(1'b1, (NW*WW)'(16'h1234), 1'b0, 1'b0);
    cyc(1'b1, (NW*WW)'(16'h5678), 1'b0, 1'b1);
    repeat (3) cyc(1'b0, rnd_words(), 1'b1, 1'b0);

    // Two beats queued then drained
    cyc(1'b1, (NW*WW)'(16'hAAAA), 1'b0, 1'b0);
    cyc(1'b1, (NW*WW)'(16'hBBBB), 1'b0, 1'b0);
    repeat (4) cyc(1'b0, rnd_words(), 1'b1, 1'b0);

    // Long stall to saturate the 4-bit counter
    cyc(1'b1, rnd_words(), 1'b0, 1'b0);
    repeat (20) cyc(1'b0, rnd_words(), 1'b0, 1'b0);
    chk(s_stall_count == 4'hF, "sat_stops_at_F", 128'(s_stall_count), 128'(4'hF));
    repeat (3) cyc(1'b0, rnd_words(), 1'b1, 1'b0);

    // Asynchronous reset while a beat is held and stalled
    cyc(1'b1, (NW*WW)'(16'hC0DE), 1'b0, 1'b0);
    cyc(1'b0, rnd_words(), 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk(out_valid == 1'b0, "async_rst_valid", 128'(out_valid), 128'(0));
    chk(out_words == '0, "async_rst_words", 128'(out_words), 128'(0));
    chk(stall_count == '0, "async_rst_stall", 128'(stall_count), 128'(0));
    @(posedge clk);
    #1 reset = 1'b0;
    #1 chk(in_ready == 1'b1, "ready_after_midreset", 128'(in_ready), 128'(1));
    #1;

    // Random traffic
    for (int unsigned i = 0; i < 3000; i++)
      cyc($urandom_range(0, 9) < 7, rnd_words(), $urandom_range(0, 9) < 6,
          $urandom_range(0, 39) == 0);
    repeat (4) cyc(1'b0, rnd_words(), 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
